// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID definitions: default widths, bubble encoding and stall-counter width.
package if_id_defs;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF   = 32;
  localparam int unsigned STALL_CNT_W   = 16;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Saturating increment for the stall performance counter.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    if (v == {STALL_CNT_W{1'b1}}) return v;
    return v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// One-entry skid buffer holding a fetched (npc, instr) pair while the IF/ID stage is held.
module if_id_skid #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  wr_npc,
  input  logic [INSTR_W-1:0] wr_instr,
  output logic               full,
  output logic [ADDR_W-1:0]  rd_npc,
  output logic [INSTR_W-1:0] rd_instr
);

  // Valid flag: clear wins over write, write wins over read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_npc   <= '0;
      rd_instr <= '0;
    end else if (wr_en && !clr) begin
      rd_npc   <= wr_npc;
      rd_instr <= wr_instr;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with stall, flush and a one-entry skid buffer.
// Optional stall performance counter enabled by defining IF_ID_PERF_EN.
module if_id_skid_reg
  import if_id_defs::*;
#(
  parameter int unsigned          ADDR_W    = ADDR_W_DEF,
  parameter int unsigned          INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instruction_hit,
  input  logic               data_hit,
  input  logic               hazard_stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  npc,
  input  logic [INSTR_W-1:0] instr,
  output logic               in_ready,
`ifdef IF_ID_PERF_EN
  output logic [STALL_CNT_W-1:0] stall_cycles,
`endif
  output logic               out_valid,
  output logic [ADDR_W-1:0]  npcout,
  output logic [INSTR_W-1:0] instrout
);

  logic               skid_full;
  logic [ADDR_W-1:0]  skid_npc;
  logic [INSTR_W-1:0] skid_instr;
  logic               accept_c;
  logic               hold_c;
  logic               skid_wr_c;
  logic               skid_rd_c;

  // in_ready comes straight off the skid flop so fetch sees no input-to-output path.
  assign in_ready  = ~skid_full;
  assign accept_c  = in_valid & instruction_hit & ~skid_full;
  assign hold_c    = ~data_hit | hazard_stall;
  assign skid_wr_c = ~flush & hold_c & accept_c;
  assign skid_rd_c = ~flush & ~hold_c & skid_full;

  if_id_skid #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (skid_wr_c),
    .rd_en    (skid_rd_c),
    .clr      (flush),
    .wr_npc   (npc),
    .wr_instr (instr),
    .full     (skid_full),
    .rd_npc   (skid_npc),
    .rd_instr (skid_instr)
  );

  // Output registers: flush > hold > drain skid > accept > bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      npcout    <= '0;
      instrout  <= NOP_INSTR;
    end else if (flush) begin
      out_valid <= 1'b0;
      npcout    <= '0;
      instrout  <= NOP_INSTR;
    end else if (hold_c) begin
      out_valid <= out_valid;
    end else if (skid_full) begin
      out_valid <= 1'b1;
      npcout    <= skid_npc;
      instrout  <= skid_instr;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      npcout    <= npc;
      instrout  <= instr;
    end else begin
      out_valid <= 1'b0;
      instrout  <= NOP_INSTR;
    end
  end

`ifdef IF_ID_PERF_EN
  // Counts edges where a real instruction sits frozen in decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hold_c && out_valid) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed, table-driven bench for if_id_skid_reg plus hand-written corner sequences.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instruction_hit, data_hit, hazard_stall, flush, in_valid;
  logic [31:0] npc, instr;
  logic        in_ready, out_valid;
  logic [31:0] npcout, instrout;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk             (clk),
    .rst             (rst),
    .instruction_hit (instruction_hit),
    .data_hit        (data_hit),
    .hazard_stall    (hazard_stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .npc             (npc),
    .instr           (instr),
    .in_ready        (in_ready),
`ifdef IF_ID_PERF_EN
    .stall_cycles    (stall_cycles),
`endif
    .out_valid       (out_valid),
    .npcout          (npcout),
    .instrout        (instrout)
  );

  typedef struct {
    logic        v, ih, dh, hs, fl;
    logic [31:0] npc, instr;
    logic        e_ov;
    logic [31:0] e_npc, e_instr;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [31:0] n,
                           input logic [31:0] i, input logic rdy);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".npcout"},    npcout,         n);
    check({tag, ".instrout"},  instrout,       i);
    check({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ih, input logic dh, input logic hs,
                       input logic fl, input logic [31:0] n, input logic [31:0] i);
    in_valid = v; instruction_hit = ih; data_hit = dh; hazard_stall = hs; flush = fl;
    npc = n; instr = i;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 32'h0, 32'h0);
    tick;
    #2 rst = 1'b0;
  endtask

  initial begin
    //          v  ih dh hs fl npc     instr          ov npc     instr          rdy
    vecs[0]  = '{1, 1, 1, 0, 0, 32'd10, 32'd10,       1, 32'd10, 32'd10,       1};
    vecs[1]  = '{1, 1, 1, 0, 0, 32'd4,  32'h104,      1, 32'd4,  32'h104,      1};
    vecs[2]  = '{1, 1, 1, 0, 0, 32'd8,  32'h108,      1, 32'd8,  32'h108,      1};
    vecs[3]  = '{1, 1, 0, 0, 0, 32'd12, 32'h10C,      1, 32'd8,  32'h108,      0};
    vecs[4]  = '{1, 1, 0, 0, 0, 32'd16, 32'h110,      1, 32'd8,  32'h108,      0};
    vecs[5]  = '{1, 1, 0, 0, 0, 32'd16, 32'h110,      1, 32'd8,  32'h108,      0};
    vecs[6]  = '{1, 1, 1, 0, 0, 32'd16, 32'h110,      1, 32'd12, 32'h10C,      1};
    vecs[7]  = '{1, 1, 1, 0, 0, 32'd16, 32'h110,      1, 32'd16, 32'h110,      1};
    vecs[8]  = '{1, 0, 1, 0, 0, 32'd20, 32'h114,      0, 32'd16, NOP,          1};
    vecs[9]  = '{1, 1, 1, 0, 0, 32'd20, 32'h114,      1, 32'd20, 32'h114,      1};
    vecs[10] = '{1, 1, 1, 1, 0, 32'd24, 32'h118,      1, 32'd20, 32'h114,      0};
    vecs[11] = '{1, 1, 1, 1, 1, 32'd28, 32'h11C,      0, 32'd0,  NOP,          1};
    vecs[12] = '{0, 1, 1, 0, 0, 32'd28, 32'h11C,      0, 32'd0,  NOP,          1};
    vecs[13] = '{1, 1, 1, 0, 1, 32'd32, 32'h120,      0, 32'd0,  NOP,          1};
    vecs[14] = '{1, 1, 1, 0, 0, 32'd36, 32'h124,      1, 32'd36, 32'h124,      1};
    vecs[15] = '{1, 0, 0, 0, 0, 32'd40, 32'h128,      1, 32'd36, 32'h124,      1};
    vecs[16] = '{0, 1, 1, 0, 0, 32'd40, 32'h128,      0, 32'd36, NOP,          1};

    do_reset;
    check_all("reset", 1'b0, 32'h0, NOP, 1'b1);

    for (int k = 0; k < 17; k++) begin
      drive(vecs[k].v, vecs[k].ih, vecs[k].dh, vecs[k].hs, vecs[k].fl,
            vecs[k].npc, vecs[k].instr);
      tick;
      check_all($sformatf("vec%0d", k), vecs[k].e_ov, vecs[k].e_npc, vecs[k].e_instr,
                vecs[k].e_rdy);
    end

    // Asynchronous reset while the skid holds a word.
    do_reset;
    drive(1, 1, 1, 0, 0, 32'h40, 32'h240);
    tick;
    check_all("pre_hold", 1'b1, 32'h40, 32'h240, 1'b1);
    drive(1, 1, 0, 0, 0, 32'h44, 32'h244);
    tick;
    check_all("skid_full", 1'b1, 32'h40, 32'h240, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 32'h0, NOP, 1'b1);
    #1 rst = 1'b0;
    drive(1, 1, 1, 0, 0, 32'h48, 32'h248);
    tick;
    check_all("post_rst", 1'b1, 32'h48, 32'h248, 1'b1);

`ifdef IF_ID_PERF_EN
    do_reset;
    check("perf_reset", 32'(stall_cycles), 32'd0);
    drive(1, 1, 1, 0, 0, 32'h60, 32'h260);
    tick;
    drive(0, 1, 1, 1, 0, 32'h64, 32'h264);
    for (int k = 0; k < 5; k++) tick;
    check("perf_5", 32'(stall_cycles), 32'd5);
    check("perf_5.out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 70000; k++) tick;
    check("perf_sat", 32'(stall_cycles), 32'h0000_FFFF);
    drive(0, 1, 1, 0, 0, 32'h0, 32'h0);
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
